reaction_timer_svc: RTL and testbench
=====================================

# reaction_timer_svc

Timing-service block for the reaction-time health monitor: the responder side of the wait/timer handshake driven by the reaction-game controller FSM. Accepts `start_rwait`, `start_wait5`, `time_en`, `time_clr` and returns `rwait_done`, `wait5_done`, `time_late`. It also returns the measured reaction time in milliseconds for the display path. It contains a pseudo-random wait generator, a fixed 5 s penalty/timeout wait, and a saturating millisecond reaction counter.

## Interface
- `CLK_FREQ_HZ`, 100_000_000 — system clock frequency; `TICKS_PER_MS = CLK_FREQ_HZ/1000`, must be ≥ 2.
- `RWAIT_MIN_MS`, 1000 — minimum random wait.
- `WAIT5_MS`, 5000 — fixed wait length.
- `LATE_MS`, 1000 — reaction-time limit.
- `clk  in  1` — system clock.
- `rst_n  in  1` — reset, asynchronous, active-low.
- `start_rwait  in  1` — level request for a random wait; held high for the whole wait.
- `start_wait5  in  1` — level request for the fixed wait; held high for the whole wait.
- `time_en  in  1` — reaction counter counts while high.
- `time_clr  in  1` — synchronous clear of the reaction counter and its prescaler.
- `rwait_done  out  1` — random wait expired; level.
- `wait5_done  out  1` — fixed wait expired; level.
- `time_late  out  1` — `ms_count >= LATE_MS`.
- `ms_count  out  14` — reaction time in ms, 0..9999.

## Operation
- **Reset** (`rst_n` = 0, async): all outputs 0, `ms_count` = 0, both wait channels IDLE, LFSR = 16'hACE1, all prescalers 0.
- **LFSR**: 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, steps every clock, never reaches 0.
- **Wait channels**: two independent copies of a 3-state FSM: IDLE → RUN → DONE.
  - IDLE → RUN: on the clock edge that samples the request high while the channel is IDLE.
    - On that edge: load the target and clear the channel prescaler and ms count.
    - rwait target = `RWAIT_MIN_MS + lfsr[11:0]` (range 1000..5095 ms).
    - wait5 target = `WAIT5_MS`.
  - RUN: ms count increments on each channel `ms_tick`. When it equals the target, go to DONE.
  - DONE: `*_done` = 1.
  - Leaving RUN or DONE: request low for one sampled edge → IDLE. `*_done` is 0 from the next cycle.
  - An aborted RUN never asserts done.
  - A request still high in DONE stays DONE; it does not retrigger.
- **Reaction counter**:
  - `time_clr` high: `ms_count` ← 0 and reaction prescaler ← 0. Clear has priority over `time_en`.
  - Otherwise, `time_en` high and a reaction tick: `ms_count` += 1, saturating at 9999.
  - `time_en` low: prescaler and count hold.
- **`time_late`**: combinational compare on registered `ms_count`, so it is registered-equivalent. It stays high while the count is held.
- **Simultaneous events**:
  - Both wait requests may be active at once; the channels run independently.
  - Wait channels ignore `time_clr` and `time_en`.

## Timing
- **Prescaler**: counts 0..`TICKS_PER_MS`−1. `ms_tick` pulses for one cycle when the count is `TICKS_PER_MS`−1.
- **Wait latency**: `*_done` rises exactly `target × TICKS_PER_MS` cycles after the edge that starts RUN.
- **Done drop**: `*_done` falls one cycle after the request is sampled low.
- **Reaction counter**: `ms_count` increments `TICKS_PER_MS` cycles after the first enabled cycle following a clear, then every `TICKS_PER_MS` enabled cycles.
- **`time_late`** rises in the same cycle that `ms_count` reaches `LATE_MS`.
- **Reset mid-operation**: reset state is immediate and no done pulses appear. The first request edge sampled after release starts normally.

## Structure
- **`reaction_pkg`**: `wait_state_t` enum (IDLE, RUN, DONE), `MS_MAX = 14'd9999`, `LFSR_SEED = 16'hACE1`, `LFSR_TAPS = 16'hB400`, `MS_W = 14`.
- **Sub-module `ms_prescaler`**: ports `clk`, `rst_n`, `clr`, `en`, `tick`. Parameter `TICKS_PER_MS`.
  - Instantiated three times: rwait channel, wait5 channel, reaction counter.
  - Wait-channel instances have `en` = 1 and `clr` = channel start.
- Wait channel logic is written once as a generate loop or as two identical always blocks keyed on the package enum.

## Test plan
All scenarios use `CLK_FREQ_HZ` = 10_000 (10 cycles/ms), `WAIT5_MS` = 20, `LATE_MS` = 50, `RWAIT_MIN_MS` = 4.

- **Fixed wait**: `start_wait5` held high → `wait5_done` rises exactly 200 cycles after the start edge and stays high; drop `start_wait5` → `wait5_done` = 0 the next cycle.
- **Random wait**: `start_rwait` rises; bench model predicts `lfsr[11:0]` = k from the seed and cycle count → `rwait_done` rises at (4+k)×10 cycles. Repeat 3 times to check the targets differ.
- **Abort**: `start_rwait` high for 15 cycles then low → `rwait_done` never asserts; a new request restarts the full wait.
- **Reaction timing**: `time_clr` 1 cycle, then `time_en` high for 499 cycles → `ms_count` = 49 and `time_late` = 0.
  - 1 more cycle → `ms_count` = 50 and `time_late` = 1.
  - `time_clr` and `time_en` both high → `ms_count` = 0 next cycle.
- **Saturation**: `time_en` high for 100_050 cycles → `ms_count` holds at 9999.
- **Reset mid-run**: `rst_n` low during a wait5 RUN and a counting reaction → all outputs 0 immediately; after release with `start_wait5` still high → a fresh 200-cycle wait completes.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time timing service.
package reaction_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } wait_state_t;

   localparam int              MS_W      = 14;
   localparam logic [MS_W-1:0] MS_MAX    = 14'd9999;
   localparam logic [15:0]     LFSR_SEED = 16'hACE1;
   localparam logic [15:0]     LFSR_TAPS = 16'hB400;

   // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Divides the system clock down to a one-cycle millisecond tick.
module ms_prescaler #(
   parameter int TICKS_PER_MS = 100_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int             CW   = $clog2(TICKS_PER_MS);
   localparam logic [CW-1:0]  LAST = CW'(TICKS_PER_MS - 1);

   logic [CW-1:0] cnt;

   assign tick = en && !clr && (cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/reaction_timer_svc.sv
// Timing service for the reaction-game controller: random wait, fixed wait
// and a saturating millisecond reaction counter.
module reaction_timer_svc
   import reaction_pkg::*;
#(
   parameter int CLK_FREQ_HZ  = 100_000_000,
   parameter int RWAIT_MIN_MS = 1000,
   parameter int WAIT5_MS     = 5000,
   parameter int LATE_MS      = 1000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_rwait,
   input  logic            start_wait5,
   input  logic            time_en,
   input  logic            time_clr,
   output logic            rwait_done,
   output logic            wait5_done,
   output logic            time_late,
   output logic [MS_W-1:0] ms_count
);

   localparam int TICKS_PER_MS = CLK_FREQ_HZ / 1000;

   logic [15:0]                lfsr;
   logic [1:0]                 req;
   logic [1:0]                 done;
   logic [1:0][MS_W-1:0]       load_tgt;
   logic                       react_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= LFSR_SEED;
      else        lfsr <= lfsr_next(lfsr);
   end

   // Channel 0 is the random wait, channel 1 the fixed wait.
   assign req         = {start_wait5, start_rwait};
   assign load_tgt[0] = MS_W'(RWAIT_MIN_MS) + MS_W'(lfsr[11:0]);
   assign load_tgt[1] = MS_W'(WAIT5_MS);

   for (genvar c = 0; c < 2; c++) begin : g_chan
      wait_state_t     state, state_nx;
      logic [MS_W-1:0] cnt;
      logic [MS_W-1:0] target;
      logic            start;
      logic            tick;

      assign start   = (state == IDLE) && req[c];
      assign done[c] = (state == DONE);

      ms_prescaler #(.TICKS_PER_MS(TICKS_PER_MS)) u_pre (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (start),
         .en    (1'b1),
         .tick  (tick)
      );

      // NOTE: next state is defaulted before the case so no path leaves it
      // unassigned and no latch is inferred.
      always_comb begin
         state_nx = state;
         case (state)
            IDLE: if (req[c]) state_nx = RUN;
            RUN: begin
               if (!req[c])                             state_nx = IDLE;
               else if (tick && (cnt + 1'b1) == target) state_nx = DONE;
            end
            DONE:    if (!req[c]) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            target <= '0;
         end else begin
            state <= state_nx;
            if (start) begin
               target <= load_tgt[c];
               cnt    <= '0;
            end else if (state == RUN && req[c] && tick) begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign rwait_done = done[0];
   assign wait5_done = done[1];

   ms_prescaler #(.TICKS_PER_MS(TICKS_PER_MS)) u_react_pre (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (time_clr),
      .en    (time_en),
      .tick  (react_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms_count <= '0;
      end else if (time_clr) begin
         ms_count <= '0;
      end else if (react_tick && ms_count != MS_MAX) begin
         ms_count <= ms_count + 1'b1;
      end
   end

   assign time_late = (ms_count >= MS_W'(LATE_MS));

endmodule

// File: tb/tb_reaction_timer_svc.sv
// Directed bench for reaction_timer_svc: wait latencies, abort, reaction
// counting, late flag, saturation and mid-run reset.
module tb_reaction_timer_svc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_rwait, start_wait5, time_en, time_clr;
   logic        rwait_done, wait5_done, time_late;
   logic [13:0] ms_count;

   logic        sat_en, sat_clr, sat_idle;
   logic        sat_rwait_done, sat_wait5_done, sat_late;
   logic [13:0] sat_count;

   logic [15:0] m_lfsr;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   reaction_timer_svc #(
      .CLK_FREQ_HZ(10_000), .RWAIT_MIN_MS(4), .WAIT5_MS(20), .LATE_MS(50)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .start_rwait(start_rwait), .start_wait5(start_wait5),
      .time_en(time_en), .time_clr(time_clr),
      .rwait_done(rwait_done), .wait5_done(wait5_done),
      .time_late(time_late), .ms_count(ms_count)
   );

   // Two cycles per ms so the 9999 ms saturation point is reachable quickly.
   reaction_timer_svc #(
      .CLK_FREQ_HZ(2_000), .RWAIT_MIN_MS(4), .WAIT5_MS(20), .LATE_MS(50)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .start_rwait(sat_idle), .start_wait5(sat_idle),
      .time_en(sat_en), .time_clr(sat_clr),
      .rwait_done(sat_rwait_done), .wait5_done(sat_wait5_done),
      .time_late(sat_late), .ms_count(sat_count)
   );

   // Reference LFSR: x^16+x^14+x^13+x^11+1, seeded 0xACE1, steps every clock.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)        m_lfsr <= 16'hACE1;
      else if (m_lfsr[0]) m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
      else               m_lfsr <= m_lfsr >> 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Waits (bounded) for a small random offset so each random wait stays short.
   task automatic wait_small_k(output int k);
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (m_lfsr[11:8] == 4'h0) break;
      end
      k = int'(m_lfsr[11:0]);
   endtask

   // Cycles from the start edge until each done is first seen; -1 if never.
   task automatic measure(input bit want_rw, input bit want_w5, input int bound,
                          output int rw_lat, output int w5_lat);
      rw_lat = -1;
      w5_lat = -1;
      for (int i = 1; i <= bound; i++) begin
         @(negedge clk);
         if (rwait_done && rw_lat < 0) rw_lat = i - 1;
         if (wait5_done && w5_lat < 0) w5_lat = i - 1;
         if ((!want_rw || rw_lat >= 0) && (!want_w5 || w5_lat >= 0)) break;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int k, k2, rl, wl, seen;
      start_rwait = 1'b0; start_wait5 = 1'b0; time_en = 1'b0; time_clr = 1'b0;
      sat_en = 1'b0; sat_clr = 1'b0; sat_idle = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_rwait_done", int'(rwait_done), 0);
      check("rst_wait5_done", int'(wait5_done), 0);
      check("rst_time_late", int'(time_late), 0);
      check("rst_ms_count", int'(ms_count), 0);
      check("rst_sat_count", int'(sat_count), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Fixed wait: 20 ms at 10 cycles/ms.
      start_wait5 = 1'b1;
      measure(1'b0, 1'b1, 260, rl, wl);
      check("wait5_latency", wl, 200);
      check("wait5_no_rwait", rl, -1);
      repeat (5) @(negedge clk);
      check("wait5_held", int'(wait5_done), 1);
      start_wait5 = 1'b0;
      @(negedge clk);
      check("wait5_drop", int'(wait5_done), 0);

      // Random waits.
      for (int r = 0; r < 3; r++) begin
         wait_small_k(k);
         start_rwait = 1'b1;
         measure(1'b1, 1'b0, (4 + k) * 10 + 20, rl, wl);
         check($sformatf("rwait_latency_%0d_k%0d", r, k), rl, (4 + k) * 10);
         start_rwait = 1'b0;
         @(negedge clk);
         check($sformatf("rwait_drop_%0d", r), int'(rwait_done), 0);
         repeat (3) @(negedge clk);
      end

      // Both channels at once.
      wait_small_k(k);
      start_rwait = 1'b1;
      start_wait5 = 1'b1;
      measure(1'b1, 1'b1, ((4 + k) * 10 > 200 ? (4 + k) * 10 : 200) + 20, rl, wl);
      check("both_rwait_latency", rl, (4 + k) * 10);
      check("both_wait5_latency", wl, 200);
      start_rwait = 1'b0;
      start_wait5 = 1'b0;
      @(negedge clk);
      check("both_drop_rwait", int'(rwait_done), 0);
      check("both_drop_wait5", int'(wait5_done), 0);

      // Abort after 15 cycles, then a fresh full wait.
      wait_small_k(k);
      start_rwait = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (rwait_done) seen = 1;
      end
      start_rwait = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (rwait_done) seen = 1;
      end
      check("abort_no_done", seen, 0);
      wait_small_k(k2);
      start_rwait = 1'b1;
      measure(1'b1, 1'b0, (4 + k2) * 10 + 20, rl, wl);
      check("restart_latency", rl, (4 + k2) * 10);
      start_rwait = 1'b0;
      @(negedge clk);

      // Reaction counter and late flag.
      time_clr = 1'b1;
      @(negedge clk);
      time_clr = 1'b0;
      time_en  = 1'b1;
      repeat (499) @(negedge clk);
      check("react_499_count", int'(ms_count), 49);
      check("react_499_late", int'(time_late), 0);
      @(negedge clk);
      check("react_500_count", int'(ms_count), 50);
      check("react_500_late", int'(time_late), 1);
      time_en = 1'b0;
      repeat (30) @(negedge clk);
      check("react_hold_count", int'(ms_count), 50);
      check("react_hold_late", int'(time_late), 1);
      time_clr = 1'b1;
      time_en  = 1'b1;
      @(negedge clk);
      check("react_clr_prio_count", int'(ms_count), 0);
      check("react_clr_prio_late", int'(time_late), 0);
      time_clr = 1'b0;
      time_en  = 1'b0;

      // Reset during a wait5 run and an active count.
      time_clr = 1'b1;
      @(negedge clk);
      time_clr    = 1'b0;
      time_en     = 1'b1;
      start_wait5 = 1'b1;
      repeat (120) @(negedge clk);
      check("pre_reset_count", int'(ms_count), 12);
      rst_n   = 1'b0;
      time_en = 1'b0;
      #1;
      check("mid_reset_count", int'(ms_count), 0);
      check("mid_reset_wait5", int'(wait5_done), 0);
      check("mid_reset_rwait", int'(rwait_done), 0);
      check("mid_reset_late", int'(time_late), 0);
      @(negedge clk);
      rst_n = 1'b1;
      measure(1'b0, 1'b1, 260, rl, wl);
      check("post_reset_wait5_latency", wl, 200);
      start_wait5 = 1'b0;
      @(negedge clk);

      // Saturation at 9999 ms on the fast-prescaler instance.
      sat_clr = 1'b1;
      @(negedge clk);
      sat_clr = 1'b0;
      sat_en  = 1'b1;
      repeat (19_996) @(negedge clk);
      check("sat_9998", int'(sat_count), 9998);
      repeat (2) @(negedge clk);
      check("sat_9999", int'(sat_count), 9999);
      repeat (20) @(negedge clk);
      check("sat_hold", int'(sat_count), 9999);
      check("sat_late", int'(sat_late), 1);
      sat_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
